// File: rtl/mux_scan_collector_pkg.sv
// Shared types and helpers for the mux scan collector: FSM state encoding,
// default channel count and the select-width derivation.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 4;

    // A single-channel mux still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_collector_if.sv
// Bundle of the scan-control, mux-facing and frame-handshake signals of the
// collector. The collector is the master; its environment is the slave.
interface mux_scan_collector_if #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic              start;
    logic              cont;
    logic [SEL_W-1:0]  sel;
    logic              y;
    logic [NUM_CH-1:0] frame;
    logic              frame_valid;
    logic              frame_ready;
    logic              busy;
    logic              overrun;
    logic              overrun_clr;

    modport master (
        input  start, cont, y, frame_ready, overrun_clr,
        output sel, frame, frame_valid, busy, overrun
    );

    modport slave (
        output start, cont, y, frame_ready, overrun_clr,
        input  sel, frame, frame_valid, busy, overrun
    );
endinterface

// File: rtl/mux_scan_collector.sv
// Walks the external mux select through every channel, samples y after a
// programmable settle time and presents the collected bits as one frame.
module mux_scan_collector
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = sel_width(NUM_CH),
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_scan_collector_if.master bus
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic              fv_q, fv_d;
    logic              ov_q, ov_d;
    logic              busy_q, busy_d;
    logic              accept_s;
    logic              load_s;
    logic              drop_s;

    assign accept_s = fv_q & bus.frame_ready;

    // Next-state, select/counter sequencing, frame load and overrun decision.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fv_d     = fv_q;
        ov_d     = ov_q;
        load_s   = 1'b0;
        drop_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                cnt_d = '0;
                if (bus.start || bus.cont) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                shadow_d[sel_q] = bus.y;
                cnt_d           = '0;
                if (sel_q != SEL_W'(NUM_CH - 1)) begin
                    sel_d   = sel_q + {{(SEL_W-1){1'b0}}, 1'b1};
                    state_d = ST_SETTLE;
                end else begin
                    // Slot counts as free when the consumer takes the old frame this cycle.
                    if (!fv_q || accept_s) begin
                        load_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                    sel_d = '0;
                    if (bus.cont) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase

        if (load_s) begin
            frame_d = shadow_d;
            fv_d    = 1'b1;
        end else if (accept_s) begin
            fv_d = 1'b0;
        end else begin
            fv_d = fv_q;
        end

        if (drop_s) begin
            ov_d = 1'b1;
        end else if (bus.overrun_clr) begin
            ov_d = 1'b0;
        end else begin
            ov_d = ov_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            ov_q     <= ov_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = fv_q;
    assign bus.overrun     = ov_q;
    assign bus.busy        = busy_q;

endmodule

// File: doc/mux_scan_collector.md
Name: mux_scan_collector

Overview:
- Sequential front-end that drives the select input of the team's existing 4:1 multiplexer (mux_4to1).
- Walks sel through every channel and waits a programmable settle time on each one.
- Samples the mux output y on each channel and assembles the samples into one parallel frame.
- Presents the frame on a valid/ready handshake. It sits directly around the mux: it produces sel and consumes y.

Parameters:
- NUM_CH, default 4: number of mux channels scanned. Must be at least 2 and a power of two.
- SEL_W, default 2: width of sel. Must equal $clog2(NUM_CH).
- SETTLE, default 1: cycles sel is held before y is sampled. Must be at least 1.
- CNT_W, default 4: settle counter width. Must satisfy 2**CNT_W > SETTLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request for one scan; honoured only in IDLE
- cont  input  1  continuous mode; when high, scanning restarts automatically after each frame
- sel  output  SEL_W  select to mux_4to1
- y  input  1  mux output
- frame  output  NUM_CH  assembled frame; frame[i] is the y value sampled while sel==i
- frame_valid  output  1  frame holds an unconsumed result
- frame_ready  input  1  consumer accepts frame when high together with frame_valid
- busy  output  1  high whenever state is not IDLE
- overrun  output  1  sticky flag: a completed frame was dropped
- overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- One clock is used throughout. Reset is asynchronous and active-low (clk / rst_n).
- Reset values: all outputs 0; state IDLE; internal shadow register 0; settle counter 0.
- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - sel=0.
  - If start or cont is high: go to SETTLE with sel=0 and counter=0. Otherwise stay in IDLE.
- SETTLE:
  - Counter increments each cycle. When counter==SETTLE-1, go to SAMPLE.
  - sel is stable for exactly SETTLE cycles plus the SAMPLE cycle.
- SAMPLE (one cycle):
  - shadow[sel] <= y.
  - If sel < NUM_CH-1: sel increments, counter is cleared, go to SETTLE.
  - Else (last channel) the frame completes:
    - If the slot is free (frame_valid==0, or frame_valid & frame_ready this cycle): frame <= {shadow with y at bit sel}, and frame_valid <= 1.
    - Else: frame and frame_valid are unchanged, the new frame is dropped, and overrun <= 1.
    - Then sel <= 0. If cont is high go to SETTLE, else go to IDLE.
- Output handshake:
  - frame_valid clears on frame_valid & frame_ready, unless a new frame loads in the same cycle; in that case frame_valid stays 1 and frame takes the new value.
  - frame is stable while frame_valid is high and frame_ready is low.
- Latency: with start seen in cycle 0, frame_valid first rises in cycle 1+NUM_CH*(SETTLE+1), which is cycle 9 at the defaults.
- Scan rate: in continuous mode one frame completes every NUM_CH*(SETTLE+1) cycles, with no idle cycle between frames.
- start while busy: ignored. There is no queueing.
- cont deasserted mid-scan: the current frame finishes, then the block returns to IDLE.
- overrun:
  - Set on a dropped frame; held until overrun_clr.
  - If a drop and overrun_clr occur in the same cycle, set wins.
- Reset mid-scan: immediate return to reset values. The partial frame is discarded and frame_valid=0.
- busy=1 in SETTLE and SAMPLE, 0 in IDLE.

Decomposition:
- Package mux_scan_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE);
  - the default NUM_CH;
  - a SEL_W derivation helper.
- No sub-module is needed; the block is a single FSM plus registers.
- mux_4to1 stays external: the bench and top level connect sel/y between the two blocks.

Test Plan:
- Single-shot scan: a=4'b1010 on mux_4to1, SETTLE=1, pulse start in cycle 0, frame_ready=1 → sel steps 0,1,2,3, two cycles per value; frame_valid rises in cycle 9 with frame=4'b1010; busy returns to 0; frame_valid falls next cycle.
- Settle timing: SETTLE=3, a=4'b0110 → each sel value is held 4 cycles; frame=4'b0110 and frame_valid rises in cycle 17.
- Back-pressure / overrun: cont=1, frame_ready=0, a=4'b1111 → first frame=4'b1111 is held. Change a=4'b0001 before the second frame completes → overrun=1 and frame stays 4'b1111. Assert overrun_clr → overrun=0.
- Simultaneous accept and load: cont=1 with frame_ready pulsed exactly in the completing SAMPLE cycle → frame_valid stays 1, frame updates to the new value, overrun stays 0.
- Reset mid-scan: assert rst_n=0 while sel=2 → sel=0, frame=0, frame_valid=0 and busy=0 immediately (no clock edge needed). After release, a start produces a correct full frame.
- start while busy: pulse start again mid-scan → no restart; exactly one frame is produced at cycle 9.
